// File: rtl/regs_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package RegArbPkg;
   localparam int DEF_XLEN       = 64;
   localparam int DEF_STARVE_LIM = 4;

   localparam logic SRC_P0 = 1'b0;
   localparam logic SRC_P1 = 1'b1;

   typedef struct packed {
      logic [4:0]          addr;
      logic [DEF_XLEN-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/regs_wb_arbiter_fifo.sv
// Port-1 writeback queue: power-of-two depth, wrap-bit pointers, no bypass.
module regs_arb_fifo
   import RegArbPkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = wb_req_t
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  entry_t push_data,
   input  logic   pop,
   output entry_t pop_data,
   output logic   full,
   output logic   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   entry_t      mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/regs_wb_arbiter.sv
// Two-port register-file writeback arbiter with port-1 queue and starvation limit.
// Optional pending-register scoreboard enabled by REGS_WB_ARB_SCOREBOARD_EN.
module regs_wb_arbiter
   import RegArbPkg::*;
#(
   parameter int XLEN       = DEF_XLEN,
   parameter int STARVE_LIM = DEF_STARVE_LIM,
   parameter int P1_DEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            p0_valid,
   output logic            p0_ready,
   input  logic [4:0]      p0_addr,
   input  logic [XLEN-1:0] p0_data,
   input  logic            p1_valid,
   output logic            p1_ready,
   input  logic [4:0]      p1_addr,
   input  logic [XLEN-1:0] p1_data,
   input  logic            alloc_valid,
   input  logic [4:0]      alloc_addr,
   input  logic [4:0]      chk_addr_1,
   input  logic [4:0]      chk_addr_2,
   output logic            chk_busy_1,
   output logic            chk_busy_2,
   output logic            we,
   output logic [4:0]      write_addr,
   output logic [XLEN-1:0] write_data,
   output logic            grant_src
);
   typedef struct packed {
      logic [4:0]      addr;
      logic [XLEN-1:0] data;
   } req_t;

   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
   localparam logic [SW-1:0] STARVE_ONE = SW'(1);

   req_t          p1_in;
   req_t          head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          p1_push;
   logic          pop_sel;
   logic          p0_win;
   logic          at_lim;
   logic [SW-1:0] starve_cnt;

   assign at_lim   = (starve_cnt == STARVE_MAX);
   assign p1_ready = !fifo_full;
   assign p1_push  = p1_valid && !fifo_full;
   assign p0_ready = fifo_empty || !at_lim;
   assign pop_sel  = !fifo_empty && (!p0_valid || at_lim);
   assign p0_win   = p0_valid && !pop_sel;
   assign p1_in    = '{addr: p1_addr, data: p1_data};

   regs_arb_fifo #(
      .DEPTH   (P1_DEPTH),
      .entry_t (req_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (p1_push),
      .push_data (p1_in),
      .pop       (pop_sel),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Only port-0 wins over queued data count toward starvation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (pop_sel) begin
         starve_cnt <= '0;
      end else if (p0_win && !fifo_empty && !at_lim) begin
         starve_cnt <= starve_cnt + STARVE_ONE;
      end
   end

   // x0 grants are consumed but never strobe the register file.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we         <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
         grant_src  <= SRC_P0;
      end else begin
         we <= 1'b0;
         if (pop_sel) begin
            we         <= (head.addr != 5'd0);
            write_addr <= head.addr;
            write_data <= head.data;
            grant_src  <= SRC_P1;
         end else if (p0_win) begin
            we         <= (p0_addr != 5'd0);
            write_addr <= p0_addr;
            write_data <= p0_data;
            grant_src  <= SRC_P0;
         end
      end
   end

`ifdef REGS_WB_ARB_SCOREBOARD_EN
   logic [31:0] busy;

   // Set is written after clear so a same-cycle alloc keeps the register pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
      end else begin
         if (we && (grant_src == SRC_P1)) busy[write_addr] <= 1'b0;
         if (alloc_valid && (alloc_addr != 5'd0)) busy[alloc_addr] <= 1'b1;
      end
   end

   assign chk_busy_1 = (chk_addr_1 != 5'd0) && busy[chk_addr_1];
   assign chk_busy_2 = (chk_addr_2 != 5'd0) && busy[chk_addr_2];
`else
   logic unused_sb;
   assign unused_sb  = ^{alloc_valid, alloc_addr, chk_addr_1, chk_addr_2};
   assign chk_busy_1 = 1'b0;
   assign chk_busy_2 = 1'b0;
`endif
endmodule

// File: doc/regs_wb_arbiter.md
REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width.
REQ-002 SHALL have parameter STARVE_LIM, default 4, maximum consecutive port-0 grants while port-1 data waits.
REQ-003 SHALL have parameter P1_DEPTH, default 2, port-1 FIFO entries, power of two and at least 2.
REQ-004 SHALL have clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have p0_valid/p0_ready  in/out  1/1  port 0 (single-cycle pipeline writeback) handshake.
REQ-007 SHALL have p0_addr/p0_data  in  5/XLEN  port-0 destination and value.
REQ-008 SHALL have p1_valid/p1_ready  in/out  1/1  port 1 (multicycle unit writeback) handshake.
REQ-009 SHALL have p1_addr/p1_data  in  5/XLEN  port-1 destination and value.
REQ-010 SHALL have alloc_valid/alloc_addr  in  1/5  issue of a port-1 instruction, marks destination pending.
REQ-011 SHALL have chk_addr_1/chk_addr_2  in  5  source registers to test; chk_busy_1/chk_busy_2  out  1  pending flags.
REQ-012 SHALL have we/write_addr/write_data  out  1/5/XLEN  registered write port to the register file.
REQ-013 SHALL have grant_src  out  1  source of the current we pulse (0 = port 0, 1 = port 1).

Function
REQ-014 SHALL accept a port transfer only on valid && ready at a rising edge.
REQ-015 SHALL push accepted port-1 transfers into a P1_DEPTH FIFO; p1_ready = !full; no push when full, even if a pop happens in the same cycle.
REQ-016 SHALL have no FIFO bypass: minimum port-1 latency is 2 cycles from acceptance to the we pulse.
REQ-017 SHALL set p0_ready = 0 only when the FIFO is non-empty and starve_cnt == STARVE_LIM; otherwise p0_ready = 1.
REQ-018 SHALL arbitrate each cycle: FIFO non-empty and (!p0_valid or starve_cnt == STARVE_LIM) -> pop FIFO; else p0_valid -> port 0; else idle.
REQ-019 SHALL increment starve_cnt (saturating at STARVE_LIM) when port 0 wins while the FIFO is non-empty, and clear it on every FIFO pop.
REQ-020 SHALL register the winner: next cycle we = 1 with its write_addr, write_data and grant_src; idle -> we = 0, other outputs hold.
REQ-021 SHALL have a port-0 latency of exactly 1 cycle from acceptance to the we pulse.
REQ-022 SHALL consume a grant with addr 0 but drive we = 0; it still pops the FIFO and resets starve_cnt.
REQ-023 SHALL set busy[alloc_addr] on alloc_valid, ignoring addr 0, and clear busy[write_addr] on the we pulse with grant_src = 1.
REQ-024 SHALL let set win when alloc and clear target the same address in the same cycle.
REQ-025 SHALL make chk_busy_n combinational from busy[chk_addr_n], with chk_addr 0 always 0.
REQ-026 SHALL write two values to the same address in grant order: the later grant's value lands last.

Reset
REQ-027 SHALL, while rst = 0, force we = 0, write_addr = 0, write_data = 0, grant_src = 0, FIFO empty, starve_cnt = 0 and all busy = 0, with p0_ready = 1 and p1_ready = 1.
REQ-028 SHALL discard FIFO contents and pending grants on a mid-operation reset; no we is issued for them after release.
REQ-029 SHALL make the first acceptance possible at the first rising edge after rst rises.

Configuration
REQ-030 SHALL, with REGS_WB_ARB_SCOREBOARD_EN defined, implement the busy array and REQ-023 to REQ-025.
REQ-031 SHALL, without REGS_WB_ARB_SCOREBOARD_EN, contain no busy state, tie chk_busy_1 and chk_busy_2 to 0, and ignore the alloc inputs.

Structure
REQ-032 SHALL put in shared package RegArbPkg: typedef wb_req_t {addr[4:0], data[XLEN-1:0]}, the source encodings SRC_P0 = 0 and SRC_P1 = 1, and default STARVE_LIM.
REQ-033 SHALL implement the port-1 FIFO as sub-module regs_arb_fifo (wb_req_t entries, push/pop/full/empty, async active-low reset).

Verification
REQ-034 SHALL cover: p0 only, x5 = 0x11 accepted at cycle 0 -> we = 1, write_addr = 5, write_data = 0x11, grant_src = 0 at cycle 1.
REQ-035 SHALL cover: p1 only, x7 = 0xAB into an empty FIFO -> we at cycle 2, grant_src = 1.
REQ-036 SHALL cover: p0_valid held high for 10 cycles with one p1 entry queued, STARVE_LIM = 4 -> 4 port-0 grants, p0_ready = 0 for 1 cycle, port-1 grant, then port 0 resumes.
REQ-037 SHALL cover: FIFO full with p1_valid held and a pop in the same cycle -> p1_ready = 0 that cycle and no entry lost.
REQ-038 SHALL cover: alloc x9, chk_addr_1 = 9 -> busy = 1 until the port-1 write to x9; alloc x9 in that same write cycle -> busy stays 1.
REQ-039 SHALL cover: rst pulled low with 2 FIFO entries and busy[3] = 1 -> no we after release, chk_busy = 0, p1_ready = 1.
